// File: rtl/top_pkg.sv
// Constants shared between the stream-copy core and its testbench.
package top_pkg;
    localparam int CHAR_LEN = 8;
    localparam int N        = 32;
endpackage

// File: rtl/axi_lite_regs.sv
// AXI-Lite slave: ctrl, two scratch words and a read-only status word.
module axi_lite_regs #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [2:0]              status,
    output logic [1:0]              ctrl
);
    localparam int ADDR_LSB = $clog2(DATA_WIDTH/8);

    logic [DATA_WIDTH-1:0] ctrl_r, scratch1, scratch3, rd_mux;
    logic [1:0]            wr_idx, rd_idx;
    logic                  wr_en;
    logic                  unused_addr;

    assign wr_idx      = awaddr[ADDR_LSB+1:ADDR_LSB];
    assign rd_idx      = araddr[ADDR_LSB+1:ADDR_LSB];
    assign wr_en       = awready & awvalid & wvalid;
    assign bresp       = 2'b00;
    assign rresp       = 2'b00;
    assign ctrl        = ctrl_r[1:0];
    assign unused_addr = ^{awaddr, araddr};

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_d,
                                                    input logic [DATA_WIDTH-1:0] new_d,
                                                    input logic [DATA_WIDTH/8-1:0] strb);
        merge = old_d;
        for (int b = 0; b < DATA_WIDTH/8; b++)
            if (strb[b]) merge[b*8 +: 8] = new_d[b*8 +: 8];
    endfunction

    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            2'd0: rd_mux = ctrl_r;
            2'd1: rd_mux = scratch1;
            2'd2: rd_mux = {{(DATA_WIDTH-3){1'b0}}, status};
            2'd3: rd_mux = scratch3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r   <= '0;
            scratch1 <= '0;
            scratch3 <= '0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
        end else begin
            // Ready pulses for one cycle; a pending response blocks the next accept.
            awready <= awvalid && wvalid && !awready && !bvalid;
            wready  <= awvalid && wvalid && !awready && !bvalid;
            if (wr_en) begin
                case (wr_idx)
                    2'd0:    ctrl_r   <= merge(ctrl_r, wdata, wstrb);
                    2'd1:    scratch1 <= merge(scratch1, wdata, wstrb);
                    2'd3:    scratch3 <= merge(scratch3, wdata, wstrb);
                    default: ;
                endcase
                bvalid <= 1'b1;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end

            arready <= arvalid && !arready && !rvalid;
            if (arready && arvalid) begin
                rvalid <= 1'b1;
                rdata  <= rd_mux;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/top.sv
// Loads a char buffer from AXI-Stream, copies it on command, streams it back out.
module top
    import top_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [CHAR_LEN-1:0]             S_AXIS_TDATA,
    input  logic                            S_AXIS_TLAST,
    input  logic                            S_AXIS_TVALID,
    output logic                            S_AXIS_TREADY,
    output logic [CHAR_LEN-1:0]             M_AXIS_TDATA,
    output logic                            M_AXIS_TLAST,
    output logic                            M_AXIS_TVALID,
    input  logic                            M_AXIS_TREADY,
    output logic [3:0]                      led_out
);
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE, OUT} state_t;

    state_t              state, state_nxt;
    logic [1:0]          ctrl;
    logic                core_rst_n, run, run_q, run_rise;
    logic                tready_en, in_full, in_hs, out_hs, out_last, out_done;
    logic                busy, finish;
    logic [CNT_W-1:0]    in_cnt;
    logic [IDX_W-1:0]    cp_idx, out_idx;
    logic [CHAR_LEN-1:0] in_buf  [N];
    logic [CHAR_LEN-1:0] out_buf [N];
    logic                unused_prot;

    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    axi_lite_regs #(
        .DATA_WIDTH(C_S_AXI_DATA_WIDTH),
        .ADDR_WIDTH(C_S_AXI_ADDR_WIDTH)
    ) u_regs (
        .clk     (ACLK),
        .rst     (ARESETN),
        .awaddr  (S_AXI_AWADDR),
        .awvalid (S_AXI_AWVALID),
        .awready (S_AXI_AWREADY),
        .wdata   (S_AXI_WDATA),
        .wstrb   (S_AXI_WSTRB),
        .wvalid  (S_AXI_WVALID),
        .wready  (S_AXI_WREADY),
        .bresp   (S_AXI_BRESP),
        .bvalid  (S_AXI_BVALID),
        .bready  (S_AXI_BREADY),
        .araddr  (S_AXI_ARADDR),
        .arvalid (S_AXI_ARVALID),
        .arready (S_AXI_ARREADY),
        .rdata   (S_AXI_RDATA),
        .rresp   (S_AXI_RRESP),
        .rvalid  (S_AXI_RVALID),
        .rready  (S_AXI_RREADY),
        .status  ({in_full, busy, finish}),
        .ctrl    (ctrl)
    );

    assign core_rst_n    = ctrl[0];
    assign run           = ctrl[1];
    assign run_rise      = run & ~run_q;
    assign busy          = (state == RUN);
    assign finish        = (state == DONE) || (state == OUT);
    assign S_AXIS_TREADY = tready_en & ~in_full;
    assign in_hs         = S_AXIS_TVALID & S_AXIS_TREADY;
    assign M_AXIS_TVALID = (state == OUT);
    // Buffer length is whatever was loaded, so a TLAST-shortened load ends early.
    assign out_last      = ({1'b0, out_idx} == in_cnt - CNT_W'(1));
    assign M_AXIS_TLAST  = M_AXIS_TVALID & out_last;
    assign M_AXIS_TDATA  = M_AXIS_TVALID ? out_buf[out_idx] : '0;
    assign out_hs        = M_AXIS_TVALID & M_AXIS_TREADY;
    assign out_done      = out_hs & out_last;
    assign led_out       = {busy, finish, in_full, core_rst_n};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (run_rise && in_full) state_nxt = RUN;
            RUN:  if (cp_idx == LAST_IDX)  state_nxt = DONE;
            DONE: state_nxt = OUT;
            OUT:  if (out_done)            state_nxt = IDLE;
        endcase
        if (!core_rst_n) state_nxt = IDLE;
    end

    always_ff @(posedge ACLK) begin
        if (ARESETN) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge ACLK) begin
        if (ARESETN) begin
            run_q     <= 1'b0;
            tready_en <= 1'b0;
            in_full   <= 1'b0;
            in_cnt    <= '0;
            cp_idx    <= '0;
            out_idx   <= '0;
            for (int i = 0; i < N; i++) begin
                in_buf[i]  <= '0;
                out_buf[i] <= '0;
            end
        end else begin
            run_q     <= run;
            tready_en <= 1'b1;
            if (in_hs) begin
                in_buf[in_cnt[IDX_W-1:0]] <= S_AXIS_TDATA;
                in_cnt <= in_cnt + CNT_W'(1);
                if (S_AXIS_TLAST || in_cnt == CNT_W'(N - 1)) in_full <= 1'b1;
            end
            if (out_done) begin
                in_cnt  <= '0;
                in_full <= 1'b0;
            end
            // Soft reset only rewinds the core; the loaded input survives it.
            if (!core_rst_n) begin
                cp_idx  <= '0;
                out_idx <= '0;
            end else begin
                if (state == RUN) begin
                    out_buf[cp_idx] <= in_buf[cp_idx];
                    cp_idx <= (cp_idx == LAST_IDX) ? '0 : cp_idx + IDX_W'(1);
                end
                if (out_hs) out_idx <= out_last ? '0 : out_idx + IDX_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_top.sv
// Randomized bench for top: AXI-Lite register model plus queue model of the char stream.
module tb_top;
    import top_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [3:0]  S_AXI_AWADDR, S_AXI_ARADDR;
    logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic [CHAR_LEN-1:0] S_AXIS_TDATA, M_AXIS_TDATA;
    logic        S_AXIS_TLAST, S_AXIS_TVALID, S_AXIS_TREADY;
    logic        M_AXIS_TLAST, M_AXIS_TVALID, M_AXIS_TREADY;
    logic [3:0]  led_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int bcyc = 0;
    logic [CHAR_LEN-1:0] exp_q[$];
    logic [31:0] reg_model [4];

    top dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
        .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY), .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TLAST(S_AXIS_TLAST),
        .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY), .M_AXIS_TDATA(M_AXIS_TDATA),
        .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
        .led_out(led_out)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic timeout(input string what);
        total++; bad++;
        $display("FAIL %s: timed out waiting for DUT", what);
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        for (int i = 0; i < 20 && !S_AXI_AWREADY; i++) tick();
        if (!S_AXI_AWREADY) timeout("awready");
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 20 && !S_AXI_BVALID; i++) tick();
        if (!S_AXI_BVALID) timeout("bvalid");
        bcyc = cyc;
        tick();
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 20 && !S_AXI_ARREADY; i++) tick();
        if (!S_AXI_ARREADY) timeout("arready");
        tick();
        S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 20 && !S_AXI_RVALID; i++) tick();
        if (!S_AXI_RVALID) timeout("rvalid");
        d = S_AXI_RDATA;
        tick();
    endtask

    // Loads n random chars, TLAST on the last one; the model is simply the queue of chars sent.
    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            S_AXIS_TDATA  = CHAR_LEN'($urandom);
            S_AXIS_TLAST  = (i == n - 1);
            S_AXIS_TVALID = 1'b1;
            for (int k = 0; k < 20 && !S_AXIS_TREADY; k++) tick();
            if (!S_AXIS_TREADY) timeout("s_axis_tready");
            exp_q.push_back(S_AXIS_TDATA);
            tick();
        end
        S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
    endtask

    task automatic start_run(output int latency);
        axi_write(4'h0, 32'h1, 4'hf);
        axi_write(4'h0, 32'h3, 4'hf);
        for (int i = 0; i < 3 * N && !led_out[2]; i++) tick();
        if (!led_out[2]) timeout("finish");
        latency = cyc - bcyc;
    endtask

    // Drains the output stream, comparing against exp_q; optionally toggles TREADY.
    task automatic recv(input bit toggle);
        int n, got;
        bit prev_stall;
        logic [CHAR_LEN-1:0] prev_data;
        n = exp_q.size(); got = 0; prev_stall = 0; prev_data = '0;
        for (int c = 0; c < 8 * N && got < n; c++) begin
            M_AXIS_TREADY = toggle ? c[0] : 1'b1;
            if (prev_stall) begin
                total++;
                if (M_AXIS_TDATA !== prev_data) begin
                    bad++;
                    $display("FAIL stall_stable: tdata=%h held=%h", M_AXIS_TDATA, prev_data);
                end
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                total++;
                if (M_AXIS_TDATA !== exp_q[got]) begin
                    bad++;
                    $display("FAIL out_data[%0d]: got=%h exp=%h", got, M_AXIS_TDATA, exp_q[got]);
                end
                total++;
                if (M_AXIS_TLAST !== (got == n - 1)) begin
                    bad++;
                    $display("FAIL out_tlast[%0d]: got=%b exp=%b", got, M_AXIS_TLAST, (got == n - 1));
                end
                got++;
            end
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_data  = M_AXIS_TDATA;
            tick();
        end
        M_AXIS_TREADY = 1'b0;
        if (got < n) timeout("output stream");
        total++;
        if (M_AXIS_TVALID !== 1'b0) begin
            bad++;
            $display("FAIL tvalid_after_last: got=%b exp=0", M_AXIS_TVALID);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        ARESETN = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_ARADDR = '0; S_AXI_AWPROT = '0; S_AXI_ARPROT = '0;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_BREADY = 1; S_AXI_ARVALID = 0; S_AXI_RREADY = 1;
        S_AXIS_TDATA = '0; S_AXIS_TLAST = 0; S_AXIS_TVALID = 0; M_AXIS_TREADY = 0;
        repeat (3) tick();
        total++;
        if ({S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, S_AXI_AWREADY, S_AXI_BVALID,
             S_AXI_ARREADY, S_AXI_RVALID} !== 7'b0 || M_AXIS_TDATA !== '0 || S_AXI_RDATA !== '0) begin
            bad++;
            $display("FAIL reset_outputs: tready=%b tvalid=%b tdata=%h rdata=%h", S_AXIS_TREADY,
                     M_AXIS_TVALID, M_AXIS_TDATA, S_AXI_RDATA);
        end
        ARESETN = 1'b0;
        tick();
        total++;
        if (S_AXIS_TREADY !== 1'b1) begin
            bad++;
            $display("FAIL tready_after_reset: got=%b exp=1", S_AXIS_TREADY);
        end
        total++;
        if (led_out !== 4'b0000) begin
            bad++;
            $display("FAIL reset_led: got=%b exp=0000", led_out);
        end
        axi_read(4'h8, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL reset_status: got=%h exp=0", d);
        end
        axi_read(4'h0, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL reset_ctrl: got=%h exp=0", d);
        end
        for (int i = 0; i < 4; i++) reg_model[i] = '0;
    endtask

    task automatic test_regs();
        logic [31:0] d, wd;
        logic [3:0] s;
        logic [3:0] a;
        axi_write(4'h4, 32'hA5A5A5A5, 4'b0011);
        reg_model[1] = 32'h0000A5A5;
        axi_read(4'h4, d);
        total++;
        if (d !== 32'h0000A5A5) begin
            bad++;
            $display("FAIL strobe_write: got=%h exp=0000a5a5", d);
        end
        axi_write(4'h8, $urandom, 4'hf);
        axi_read(4'h8, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL status_ro: got=%h exp=0", d);
        end
        for (int i = 0; i < 6; i++) begin
            a  = (i % 2 == 0) ? 4'h4 : 4'hC;
            wd = $urandom;
            s  = 4'($urandom);
            axi_write(a, wd, s);
            for (int b = 0; b < 4; b++)
                if (s[b]) reg_model[a[3:2]][b*8 +: 8] = wd[b*8 +: 8];
            axi_read(a, d);
            total++;
            if (d !== reg_model[a[3:2]]) begin
                bad++;
                $display("FAIL scratch[%0d]: got=%h exp=%h", a[3:2], d, reg_model[a[3:2]]);
            end
        end
    endtask

    task automatic test_run(input int n, input bit toggle);
        logic [31:0] d;
        int lat;
        exp_q.delete();
        send(n);
        total++;
        if (S_AXIS_TREADY !== 1'b0 || led_out[1] !== 1'b1) begin
            bad++;
            $display("FAIL input_full n=%0d: tready=%b in_full=%b exp 0/1", n, S_AXIS_TREADY, led_out[1]);
        end
        start_run(lat);
        total++;
        if (lat > N + 4) begin
            bad++;
            $display("FAIL finish_latency: got=%0d exp<=%0d", lat, N + 4);
        end
        axi_read(4'h8, d);
        total++;
        if (d !== 32'h5) begin
            bad++;
            $display("FAIL status_finish: got=%h exp=5", d);
        end
        recv(toggle);
        total++;
        if (led_out !== 4'b0001 || S_AXIS_TREADY !== 1'b1) begin
            bad++;
            $display("FAIL after_output: led=%b tready=%b exp 0001/1", led_out, S_AXIS_TREADY);
        end
    endtask

    task automatic test_core_reset();
        int lat;
        exp_q.delete();
        send(N);
        axi_write(4'h0, 32'h2, 4'hf);
        repeat (2 * N) tick();
        total++;
        if (led_out !== 4'b0010 || M_AXIS_TVALID !== 1'b0) begin
            bad++;
            $display("FAIL held_in_reset: led=%b tvalid=%b exp 0010/0", led_out, M_AXIS_TVALID);
        end
        start_run(lat);
        recv(1'b0);
        // Abort partway through the output, then rerun the same intact buffer.
        exp_q.delete();
        send(N);
        start_run(lat);
        M_AXIS_TREADY = 1'b1;
        repeat (3) tick();
        M_AXIS_TREADY = 1'b0;
        axi_write(4'h0, 32'h2, 4'hf);
        total++;
        if (led_out !== 4'b0010 || M_AXIS_TVALID !== 1'b0) begin
            bad++;
            $display("FAIL abort_mid_out: led=%b tvalid=%b exp 0010/0", led_out, M_AXIS_TVALID);
        end
        start_run(lat);
        recv(1'b0);
    endtask

    initial begin
        test_reset();
        test_regs();
        test_run(N, 1'b0);
        test_run(5, 1'b0);
        test_run(N, 1'b1);
        test_run(7, 1'b1);
        test_core_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
